// File: rtl/bus_arbiter_tri8.sv
// rtl/bus_arbiter_tri8.sv - round-robin owner selection for a shared 8-bit tri-state bus
//
// Generates the one-hot enable vector for N per-requester 8-bit tri-state
// buffers. At most one buffer is enabled at a time, and every hand-over
// (including a regrant to the same requester) is separated by TURN_CYCLES
// cycles with all enables low, so two drivers never overlap on the bus.
//
// Optional feature: define ARB_TIMEOUT_EN to force an owner off the bus
// after MAX_HOLD consecutive cycles of ownership.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   req      in   [N]  level request per requester
//   ena      out  [N]  registered one-hot/zero buffer enables
//   gnt      out  [N]  grant to requesters, identical to ena
//   owner    out  [OW] index of current owner, valid while busy
//   busy     out  high while any ena bit is high
//   timeout  out  one-cycle pulse on forced release (0 without ARB_TIMEOUT_EN)

module bus_arbiter_tri8 #(
   parameter int N           = 4,
   parameter int TURN_CYCLES = 1,
   parameter int MAX_HOLD    = 16,
   localparam int OW         = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  ena,
   output logic [N-1:0]  gnt,
   output logic [OW-1:0] owner,
   output logic          busy,
   output logic          timeout
);

   typedef enum logic [1:0] {
      IDLE,
      OWN,
      TURN
   } state_t;

   state_t        state;
   logic [OW-1:0] ptr;
   logic [3:0]    cnt;

   logic          win_valid;
   logic [OW-1:0] win_idx;
   logic [N-1:0]  win_onehot;
   logic [OW-1:0] next_ptr;
   logic          release_own;

   // Circular search starting at ptr. Walking the offsets downwards lets the
   // smallest offset with a request overwrite the others, so the nearest
   // requester after ptr wins.
   always_comb begin
      win_valid  = 1'b0;
      win_idx    = '0;
      win_onehot = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % N]) begin
            win_valid = 1'b1;
            win_idx   = OW'((int'(ptr) + i) % N);
         end
      end
      if (win_valid) begin
         win_onehot[win_idx] = 1'b1;
      end
   end

   assign next_ptr = (int'(owner) == N - 1) ? '0 : owner + 1'b1;
   assign gnt      = ena;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] hold;
   logic       timeout_q;
   logic       hold_expired;

   // hold counts completed OWN cycles; it reaches HOLD_LAST on the
   // MAX_HOLD-th cycle with ena high, which is the last one allowed.
   assign hold_expired = (hold == HOLD_LAST);
   assign release_own  = !req[owner] || hold_expired;
   assign timeout      = timeout_q;
`else
   logic unused_max_hold;

   assign unused_max_hold = (MAX_HOLD != 0);
   assign release_own     = !req[owner];
   assign timeout         = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ena   <= '0;
         owner <= '0;
         busy  <= 1'b0;
         ptr   <= '0;
         cnt   <= '0;
`ifdef ARB_TIMEOUT_EN
         hold      <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (win_valid) begin
                  ena   <= win_onehot;
                  owner <= win_idx;
                  busy  <= 1'b1;
                  state <= OWN;
`ifdef ARB_TIMEOUT_EN
                  hold  <= '0;
`endif
               end
            end

            OWN: begin
               if (release_own) begin
                  ena   <= '0;
                  busy  <= 1'b0;
                  ptr   <= next_ptr;
                  cnt   <= 4'(TURN_CYCLES);
                  state <= TURN;
`ifdef ARB_TIMEOUT_EN
                  // Only a release the owner did not ask for is reported.
                  timeout_q <= req[owner];
`endif
               end
`ifdef ARB_TIMEOUT_EN
               else begin
                  hold <= hold + 8'd1;
               end
`endif
            end

            TURN: begin
               // The edge that takes cnt to zero is also the arbitration
               // edge, giving exactly TURN_CYCLES all-off cycles.
               if (cnt <= 4'd1) begin
                  cnt <= '0;
                  if (win_valid) begin
                     ena   <= win_onehot;
                     owner <= win_idx;
                     busy  <= 1'b1;
                     state <= OWN;
`ifdef ARB_TIMEOUT_EN
                     hold  <= '0;
`endif
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            default: begin
               state <= IDLE;
               ena   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter_tri8.sv
// tb/tb_bus_arbiter_tri8.sv - directed self-checking bench for bus_arbiter_tri8

module tb_bus_arbiter_tri8;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] ena, gnt, ena3, gnt3;
   logic [1:0] owner, owner3;
   logic       busy, timeout, busy3, timeout3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bus_arbiter_tri8 #(.N(4), .TURN_CYCLES(1), .MAX_HOLD(16)) dut (
      .clk(clk), .rst(rst), .req(req), .ena(ena), .gnt(gnt),
      .owner(owner), .busy(busy), .timeout(timeout)
   );

   // Second instance with a longer turnaround, fed the same stimulus.
   bus_arbiter_tri8 #(.N(4), .TURN_CYCLES(3), .MAX_HOLD(16)) dut3 (
      .clk(clk), .rst(rst), .req(req), .ena(ena3), .gnt(gnt3),
      .owner(owner3), .busy(busy3), .timeout(timeout3)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req = 4'hF;
      tick();
      tick();
      n_checks++;
      if (ena !== 4'b0000) begin n_fail++; $display("FAIL reset_ena: got %b want %b", ena, 4'b0000); end
      n_checks++;
      if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want %b", gnt, 4'b0000); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++;
      if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", owner); end
      n_checks++;
      if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
      rst = 1'b0;
      tick();
      n_checks++;
      if (ena !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b want %b", ena, 4'b0001); end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_first_busy: got %b want 1", busy); end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_single;
      rst = 1'b1;
      req = 4'b0000;
      tick();
      rst = 1'b0;
      req = 4'b0100;
      tick();
      for (int i = 1; i <= 4; i++) begin
         n_checks++;
         if (ena !== 4'b0100 || owner !== 2'd2) begin
            n_fail++;
            $display("FAIL single_hold c%0d: got ena=%b owner=%0d want ena=0100 owner=2", i, ena, owner);
         end
         tick();
      end
      n_checks++;
      if (ena !== 4'b0100) begin n_fail++; $display("FAIL single_c5: got %b want 0100", ena); end
      req = 4'b0000;
      tick();
      n_checks++;
      if (ena !== 4'b0000 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_release: got ena=%b busy=%b want 0000/0", ena, busy);
      end
      n_checks++;
      if (owner !== 2'd2) begin n_fail++; $display("FAIL single_owner_hold: got %0d want 2", owner); end
      tick();
      // PTR must now be 3: 3 beats 0 in the circular search.
      req = 4'b1001;
      tick();
      n_checks++;
      if (ena !== 4'b1000 || owner !== 2'd3) begin
         n_fail++;
         $display("FAIL single_ptr3: got ena=%b owner=%0d want 1000/3", ena, owner);
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_fairness;
      logic [3:0] want;
      rst = 1'b1;
      req = 4'hF;
      tick();
      rst = 1'b0;
      tick();
      for (int g = 0; g < 5; g++) begin
         want = 4'b0001 << (g % 4);
         for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (ena !== want || owner !== 2'(g % 4)) begin
               n_fail++;
               $display("FAIL rr_grant g%0d c%0d: got ena=%b owner=%0d want ena=%b owner=%0d",
                        g, c, ena, owner, want, g % 4);
            end
            n_checks++;
            if (!$onehot0(ena) || gnt !== ena || busy !== (|ena)) begin
               n_fail++;
               $display("FAIL rr_invariant g%0d c%0d: got ena=%b gnt=%b busy=%b", g, c, ena, gnt, busy);
            end
            if (c < 2) tick();
         end
         req[g % 4] = 1'b0;
         tick();
         n_checks++;
         if (ena !== 4'b0000 || gnt !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_gap g%0d: got ena=%b gnt=%b busy=%b want 0000/0000/0", g, ena, gnt, busy);
         end
         req[g % 4] = 1'b1;
         tick();
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_pointer_wrap;
      rst = 1'b1;
      req = 4'b0000;
      tick();
      rst = 1'b0;
      req = 4'b0100;
      tick();
      n_checks++;
      if (ena !== 4'b0100 || ena3 !== 4'b0100) begin
         n_fail++;
         $display("FAIL wrap_grant2: got ena=%b ena3=%b want 0100/0100", ena, ena3);
      end
      req = 4'b0001;
      tick();
      n_checks++;
      if (ena !== 4'b0000 || ena3 !== 4'b0000) begin
         n_fail++;
         $display("FAIL wrap_gap1: got ena=%b ena3=%b want 0000/0000", ena, ena3);
      end
      req = 4'b0101;
      tick();
      n_checks++;
      if (ena !== 4'b0001) begin n_fail++; $display("FAIL wrap_next: got %b want 0001", ena); end
      n_checks++;
      if (ena3 !== 4'b0000) begin n_fail++; $display("FAIL wrap3_gap2: got %b want 0000", ena3); end
      tick();
      n_checks++;
      if (ena3 !== 4'b0000) begin n_fail++; $display("FAIL wrap3_gap3: got %b want 0000", ena3); end
      tick();
      n_checks++;
      if (ena3 !== 4'b0001 || owner3 !== 2'd0) begin
         n_fail++;
         $display("FAIL wrap3_next: got ena3=%b owner3=%0d want 0001/0", ena3, owner3);
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_timeout;
      rst = 1'b1;
      req = 4'b0000;
      tick();
      rst = 1'b0;
      req = 4'b0010;
      tick();
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (ena !== 4'b0010 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_hold c%0d: got ena=%b timeout=%b want 0010/0", i, ena, timeout);
         end
         tick();
      end
      n_checks++;
      if (ena !== 4'b0000 || timeout !== 1'b1) begin
         n_fail++;
         $display("FAIL to_release: got ena=%b timeout=%b want 0000/1", ena, timeout);
      end
      tick();
      n_checks++;
      if (ena !== 4'b0010 || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL to_regrant: got ena=%b timeout=%b want 0010/0", ena, timeout);
      end
`else
      for (int i = 0; i < 100; i++) begin
         n_checks++;
         if (ena !== 4'b0010 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL nto_hold c%0d: got ena=%b timeout=%b want 0010/0", i, ena, timeout);
         end
         tick();
      end
`endif
      req = 4'b0000;
      tick();
   endtask

   task automatic test_reset_mid;
      rst = 1'b1;
      req = 4'b0000;
      tick();
      rst = 1'b0;
      req = 4'b1000;
      tick();
      n_checks++;
      if (ena !== 4'b1000 || owner !== 2'd3) begin
         n_fail++;
         $display("FAIL mid_owner3: got ena=%b owner=%0d want 1000/3", ena, owner);
      end
      req = 4'b1001;
      rst = 1'b1;
      tick();
      n_checks++;
      if (ena !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
         n_fail++;
         $display("FAIL mid_reset: got ena=%b busy=%b owner=%0d want 0000/0/0", ena, busy, owner);
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (ena !== 4'b0001 || owner !== 2'd0) begin
         n_fail++;
         $display("FAIL mid_regrant: got ena=%b owner=%0d want 0001/0", ena, owner);
      end
      req = 4'b0000;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      req = 4'b0000;
      test_reset();
      test_single();
      test_fairness();
      test_pointer_wrap();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_arbiter_tri8.md
Name: bus_arbiter_tri8

Overview:
- Round-robin arbiter sharing one 8-bit tri-state bus among N requesters.
- Each requester drives the bus through its own 8-bit tri-state buffer instance. This block generates the one-hot ENA vector feeding those buffer enables.
- Guarantees at most one driver at any time. Inserts a programmable all-off turnaround gap between owners so no two buffers ever overlap on the bus.

Parameters:
- N, 4, number of requesters (1..16).
- TURN_CYCLES, 1, cycles with all ENA low between two consecutive owners (1..15).
- MAX_HOLD, 16, max consecutive ownership cycles; used only when ARB_TIMEOUT_EN is defined (2..255).

Ports:
- CLK  input  1  clock, all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  N  level request per requester; held high for as long as the bus is wanted.
- ENA  output N  one-hot/zero enable to the per-requester tri-state buffers; registered.
- GNT  output N  grant to requesters; always identical to ENA.
- OWNER  output  max(1,$clog2(N))  index of current owner; valid while BUSY=1.
- BUSY  output  1  high while any ENA bit is high.
- TIMEOUT  output  1  one-cycle pulse when an owner is forcibly released; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Interface: one clock CLK; RST is synchronous and active-high.
- Reset: state=IDLE, ENA=0, GNT=0, OWNER=0, BUSY=0, TIMEOUT=0, rotating pointer PTR=0, turnaround counter=0.
- Reset mid-ownership: ENA drops to 0 at the edge RST is sampled high. No turnaround is applied; after reset release, arbitration restarts from PTR=0.
- States: IDLE, OWN, TURN.
- Arbitration: winner is the first REQ bit set, searching circularly from PTR (PTR, PTR+1, ..., wrap at N-1 -> 0).
- IDLE:
  - If REQ!=0 at an edge, load the winner into OWNER, set ENA/GNT one-hot, BUSY=1, go to OWN.
  - Latency: REQ rises in cycle c -> ENA visible in cycle c+1.
- OWN:
  - Hold ENA while REQ[OWNER]=1. REQ of non-owners is ignored.
  - When REQ[OWNER]=0 is sampled: ENA=0, BUSY=0, PTR=(OWNER+1) mod N, counter=TURN_CYCLES, go to TURN.
- TURN:
  - Decrement the counter each cycle; ENA stays 0.
  - On the edge where the counter reaches 0: if REQ!=0, arbitrate and go straight to OWN; otherwise go to IDLE.
  - Result: ENA is all-zero for exactly TURN_CYCLES cycles between any two ownerships, including same-requester regrant.
- An owner that drops REQ and re-raises it always passes through TURN and is arbitrated against everyone from the new PTR, so it cannot starve others.
- N=1: PTR stays 0. Behaviour is otherwise identical; a turnaround is still applied between ownerships.
- Invariants, checked every cycle:
  - $onehot0(ENA).
  - GNT==ENA.
  - BUSY==|ENA.
  - BUSY implies ENA[OWNER]=1.
- OWNER holds its last value while BUSY=0.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on each grant and increments each OWN cycle.
  - When ENA has been high for MAX_HOLD consecutive cycles, ownership is released exactly as if REQ[OWNER] dropped: same PTR advance and TURN sequence.
  - TIMEOUT pulses high for 1 cycle, coincident with the first TURN cycle.
- Not defined: no hold counter; ownership lasts until REQ[OWNER] drops; TIMEOUT is constant 0.

Test Plan:
- All tests use N=4, TURN_CYCLES=1 unless stated.
- Reset dominance: RST=1 for 2 cycles with REQ=4'hF -> ENA=0, GNT=0, BUSY=0, OWNER=0. First edge after RST=0 -> ENA=4'b0001.
- Single request: REQ=4'b0100 from cycle 0 -> ENA=4'b0100, OWNER=2 from cycle 1. REQ low in cycle 5 -> ENA=0 cycle 6, IDLE by cycle 7, PTR=3.
- Round-robin fairness: REQ=4'hF, bench drops each owner's REQ after 3 granted cycles, then re-raises it -> grant order 0,1,2,3,0. Exactly 1 all-zero ENA cycle between grants. $onehot0(ENA) holds throughout.
- Pointer wrap: after owner 2 releases, REQ=4'b0101 -> next ENA=4'b0001 (search 3,0). Rerun with TURN_CYCLES=3 -> gap of exactly 3 cycles.
- Timeout, ARB_TIMEOUT_EN defined, MAX_HOLD=16: REQ=4'b0010 held -> ENA[1] high exactly 16 cycles, TIMEOUT one pulse, 1-cycle gap, then regrant to 1. Without the macro: ENA[1] high for all 100 test cycles, TIMEOUT=0.
- Reset mid-operation: owner 3 active, REQ=4'b1001, RST pulsed 1 cycle -> ENA=0 the next cycle. After release, grant goes to 0 (PTR reset), not 3.
